// File: rtl/adc_sar_pkg.sv
// Shared types and constants for the SAR ADC sequencer.
package adc_sar_pkg;

    localparam int ADC_BITS = 12;
    localparam int ACC_W    = ADC_BITS + 3;

    localparam logic [ADC_BITS-1:0] MSB_TRIAL = {1'b1, {(ADC_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    // Index of the final repeat for an averaging factor of 2^avg_sel.
    function automatic logic [2:0] rep_limit(input logic [1:0] avg_sel);
        return 3'((4'd1 << avg_sel) - 4'd1);
    endfunction

endpackage

// File: rtl/adc_sar_avg_accumulator.sv
// Running-sum accumulator for averaged conversions; only built when
// ADC_SAR_AVG_EN is defined.
`ifdef ADC_SAR_AVG_EN
module adc_sar_avg_accumulator
    import adc_sar_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                add,
    input  logic [ADC_BITS-1:0] word,
    input  logic [1:0]          shift,
    output logic [ADC_BITS-1:0] avg_word
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // avg_word already includes the word being added, so the final average
    // is ready on the same edge that closes the last conversion.
    assign sum      = acc + ACC_W'(word);
    assign avg_word = ADC_BITS'(sum >> shift);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule
`endif

// File: rtl/adc_sar_sequencer.sv
// SAR ADC conversion sequencer: sample, 12-bit successive approximation, done.
// Optional averaging over 2^avg_sel conversions when ADC_SAR_AVG_EN is defined.
module adc_sar_sequencer
    import adc_sar_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          sample_cycles,
    input  logic                comp,
`ifdef ADC_SAR_AVG_EN
    input  logic [1:0]          avg_sel,
`endif
    output logic [ADC_BITS-1:0] data,
    output logic                sample,
    output logic                busy,
    output logic [ADC_BITS-1:0] result,
    output logic                valid
);

    state_t              state;
    state_t              state_next;
    logic [ADC_BITS-1:0] trial;
    logic [ADC_BITS-1:0] probe;
    logic [ADC_BITS-1:0] kept_word;
    logic [ADC_BITS-1:0] final_word;
    logic [3:0]          cnt;
    logic [3:0]          samp_len;
    logic                accept;
    logic                sample_end;
    logic                conv_end;
    logic                last_rep;

    assign accept     = (state == ST_IDLE) && start;
    assign sample_end = (state == ST_SAMPLE) && (cnt == samp_len);
    assign conv_end   = (state == ST_CONVERT) && probe[0];
    // probe is the one-hot bit under test; clear it if the input is below the trial.
    assign kept_word  = comp ? trial : (trial & ~probe);
    assign data       = trial;

`ifdef ADC_SAR_AVG_EN
    logic [1:0] avg_lat;
    logic [2:0] rep_cnt;

    assign last_rep = (rep_cnt == rep_limit(avg_lat));

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_lat <= '0;
            rep_cnt <= '0;
        end else if (accept) begin
            avg_lat <= avg_sel;
            rep_cnt <= '0;
        end else if (conv_end && !last_rep) begin
            rep_cnt <= rep_cnt + 3'd1;
        end
    end

    adc_sar_avg_accumulator u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .add      (conv_end),
        .word     (kept_word),
        .shift    (avg_lat),
        .avg_word (final_word)
    );
`else
    assign last_rep   = 1'b1;
    assign final_word = kept_word;
`endif

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        busy       = 1'b1;
        valid      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                sample = 1'b1;
                if (cnt == samp_len) state_next = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (probe[0]) state_next = last_rep ? ST_DONE : ST_SAMPLE;
            end
            ST_DONE: begin
                valid      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            trial    <= '0;
            probe    <= '0;
            cnt      <= '0;
            samp_len <= '0;
            result   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                samp_len <= sample_cycles;
                cnt      <= '0;
            end
            if (state == ST_SAMPLE) begin
                if (sample_end) begin
                    cnt   <= '0;
                    trial <= MSB_TRIAL;
                    probe <= MSB_TRIAL;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
            if (state == ST_CONVERT) begin
                if (probe[0]) begin
                    trial <= '0;
                    probe <= '0;
                    if (last_rep) result <= final_word;
                end else begin
                    trial <= kept_word | (probe >> 1);
                    probe <= probe >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed bench for adc_sar_sequencer; exercises averaging when ADC_SAR_AVG_EN is defined.
module tb_adc_sar_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  sample_cycles;
    logic        comp;
    logic [11:0] data;
    logic        sample;
    logic        busy;
    logic [11:0] result;
    logic        valid;
`ifdef ADC_SAR_AVG_EN
    logic [1:0]  avg_sel;
`endif

    logic [11:0] target;
    int          mode;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [11:0] target;
        int          sc;
        int          mode;
        logic [11:0] expect_result;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    // Comparator model: mode 0 = ideal comparator, 1 = tied high, 2 = tied low.
    always_comb begin
        comp = 1'b0;
        if (mode == 0)      comp = (target >= data);
        else if (mode == 1) comp = 1'b1;
    end

    adc_sar_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sample_cycles (sample_cycles),
        .comp          (comp),
`ifdef ADC_SAR_AVG_EN
        .avg_sel       (avg_sel),
`endif
        .data          (data),
        .sample        (sample),
        .busy          (busy),
        .result        (result),
        .valid         (valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_conv(input logic [11:0] tgt, input int sc, input int md,
                            input logic [11:0] exp);
        int n;
        bit got;
        target        = tgt;
        mode          = md;
        sample_cycles = 4'(sc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        check("sample_after_accept", 32'(sample), 32'd1);
        check("busy_after_accept", 32'(busy), 32'd1);
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == sc + 2) check("first_convert_data", 32'(data), 32'h800);
            if (valid) got = 1'b1;
        end
        check("valid_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(sc + 14));
        check("result", 32'(result), 32'(exp));
        @(negedge clk);
        check("busy_after_valid", 32'(busy), 32'd0);
        check("valid_one_cycle", 32'(valid), 32'd0);
        check("result_held", 32'(result), 32'(exp));
    endtask

    initial begin
        int n;
        int vcount;
        int v1;
        int v2;
`ifdef ADC_SAR_AVG_EN
        logic [11:0] tl[4];
        int idx;
        int busy_gap;
        bit got;
        bit prev;
`endif
        rst           = 1'b1;
        start         = 1'b0;
        sample_cycles = 4'd0;
        target        = 12'h000;
        mode          = 0;
`ifdef ADC_SAR_AVG_EN
        avg_sel       = 2'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", 32'(data), 32'd0);
        check("reset_sample", 32'(sample), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        rst = 1'b0;

        vecs[0] = '{12'hA5C, 3,  0, 12'hA5C};
        vecs[1] = '{12'h000, 0,  0, 12'h000};
        vecs[2] = '{12'hFFF, 15, 0, 12'hFFF};
        vecs[3] = '{12'h800, 1,  0, 12'h800};
        vecs[4] = '{12'h7FF, 2,  0, 12'h7FF};
        vecs[5] = '{12'h000, 3,  1, 12'hFFF};
        vecs[6] = '{12'hFFF, 0,  2, 12'h000};
        vecs[7] = '{12'h123, 5,  0, 12'h123};
        for (int i = 0; i < 8; i++)
            run_conv(vecs[i].target, vecs[i].sc, vecs[i].mode, vecs[i].expect_result);

        // Reset during CONVERT bit 5 (0xA5C: decided 101001, trial 0xA60).
        target        = 12'hA5C;
        mode          = 0;
        sample_cycles = 4'd3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (n < 11) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("bit5_trial", 32'(data), 32'hA60);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_data", 32'(data), 32'd0);
        check("abort_sample", 32'(sample), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("abort_no_valid", 32'(vcount), 32'd0);
        run_conv(12'hA5C, 3, 0, 12'hA5C);

        // Start pulses while busy are ignored.
        target        = 12'h3C3;
        sample_cycles = 4'd3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            start = (i < 12) && (i % 2 == 0);
            @(posedge clk);
            @(negedge clk);
            if (valid) vcount++;
        end
        start = 1'b0;
        check("pulsed_valid_count", 32'(vcount), 32'd1);
        check("pulsed_result", 32'(result), 32'h3C3);
        check("pulsed_idle", 32'(busy), 32'd0);

        // Start held high: back-to-back conversions with one IDLE cycle.
        target        = 12'h5A5;
        sample_cycles = 4'd2;
        v1 = -1;
        v2 = -1;
        n  = 0;
        @(negedge clk);
        start = 1'b1;
        while (v2 < 0 && n < 80) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (v1 > 0 && n == v1 + 1) check("held_idle_gap", 32'(busy), 32'd0);
            if (v1 > 0 && n == v1 + 2) check("held_resample", 32'(sample), 32'd1);
            if (valid) begin
                if (v1 < 0) v1 = n;
                else        v2 = n;
            end
        end
        start = 1'b0;
        check("held_second_valid", 32'(v2 > 0), 32'd1);
        check("held_spacing", 32'(v2 - v1), 32'd17);
        check("held_result", 32'(result), 32'h5A5);
        repeat (3) @(negedge clk);

`ifdef ADC_SAR_AVG_EN
        // Averaging x4 over targets 100,103,100,103 -> 406 >> 2 = 101.
        tl[0] = 12'd100;
        tl[1] = 12'd103;
        tl[2] = 12'd100;
        tl[3] = 12'd103;
        avg_sel       = 2'd2;
        sample_cycles = 4'd1;
        mode          = 0;
        idx      = -1;
        busy_gap = 0;
        vcount   = 0;
        got      = 1'b0;
        prev     = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (!got && n < 200) begin
            if (sample && !prev) begin
                idx++;
                if (idx < 4) target = tl[idx];
            end
            prev = sample;
            if (valid) begin
                got = 1'b1;
                vcount++;
            end else if (!busy) begin
                busy_gap++;
            end
            if (!got) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        check("avg_valid_seen", 32'(got), 32'd1);
        check("avg_result", 32'(result), 32'd101);
        check("avg_busy_gaps", 32'(busy_gap), 32'd0);
        check("avg_repeats", 32'(idx), 32'd3);
        repeat (10) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("avg_valid_count", 32'(vcount), 32'd1);
        avg_sel = 2'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_sar_sequencer.md
ADC_SAR_SEQUENCER -- requirements
Module: adc_sar_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be listed clock and reset first.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 sample_cycles  input  4  sampling-phase length minus one (0..15 -> 1..16 cycles); latched on accepted start.
REQ-006 comp  input  1  comparator decision; 1 = input above current DAC trial word; sampled on the edge ending each CONVERT cycle.
REQ-007 avg_sel  input  2  averaging factor 2^avg_sel (1,2,4,8); present only with ADC_SAR_AVG_EN; latched on accepted start.
REQ-008 data  output  12  trial word to the row/column/bincap decoder.
REQ-009 sample  output  1  high while the array tracks the input.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 result  output  12  last completed conversion result; held until the next DONE.
REQ-012 valid  output  1  one-cycle pulse when result is updated.

Function
REQ-013 The FSM SHALL have states IDLE, SAMPLE, CONVERT, DONE.
REQ-014 IDLE: start=1 -> SAMPLE next cycle; otherwise stay; data=0, sample=0.
REQ-015 SAMPLE: sample=1, data=0, lasting exactly sample_cycles+1 cycles, then CONVERT.
REQ-016 CONVERT: 12 cycles, bit index k from 11 down to 0; during bit k, data = decided bits 11..k+1, bit k = 1, bits below k = 0.
REQ-017 At the edge ending bit k, bit k SHALL be kept if comp=1 and cleared if comp=0.
REQ-018 After bit 0, the state SHALL be DONE for exactly one cycle, with valid=1 and result = final word, then IDLE.
REQ-019 Latency: the valid pulse SHALL occur sample_cycles+14 cycles after the edge that accepts start (single conversion).
REQ-020 start while busy SHALL be ignored, with no queueing; start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-021 sample_cycles and avg_sel changes while busy SHALL have no effect on the conversion in progress.

Reset
REQ-022 Reset SHALL give state=IDLE, data=0, sample=0, busy=0, result=0, valid=0, and accumulator=0.
REQ-023 Reset asserted mid-operation SHALL abort the conversion with no valid pulse and leave result=0.
REQ-024 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro ADC_SAR_AVG_EN defined: SAMPLE+CONVERT SHALL repeat 2^avg_sel times per start, with each 12-bit word summed into a 15-bit accumulator.
REQ-026 With averaging, a single DONE SHALL follow the last conversion, with result = accumulator >> avg_sel (truncating) and one valid pulse.
REQ-027 With averaging, busy SHALL remain high between repeats.
REQ-028 Macro undefined: the avg_sel port and the accumulator SHALL be absent, and behaviour SHALL equal avg_sel=0.

Structure
REQ-029 Shared package adc_sar_pkg SHALL hold: ADC_BITS=12, the state enum typedef, and the accumulator width constant (ADC_BITS+3).
REQ-030 One sub-module, adc_sar_avg_accumulator (clear, add, shift-out), SHALL be instantiated only under ADC_SAR_AVG_EN.
REQ-031 The trial-word register and FSM SHALL reside in adc_sar_sequencer.

Verification
REQ-032 Bench comparator comp = (target >= data), target=0xA5C, sample_cycles=3 -> data=0x800 on the first CONVERT cycle, result=0xA5C, valid exactly 17 cycles after start accepted.
REQ-033 comp tied 1 -> result=0xFFF; comp tied 0 -> result=0x000; both with busy low the cycle after valid.
REQ-034 rst pulsed during CONVERT bit 5 -> all outputs at reset values the next cycle, no valid pulse, next start gives the correct result.
REQ-035 start pulsed repeatedly during SAMPLE/CONVERT -> exactly one valid per accepted start; start held high -> back-to-back conversions with one IDLE cycle between DONE and SAMPLE.
REQ-036 ADC_SAR_AVG_EN, avg_sel=2, targets 100,103,100,103 per repeat -> one valid, result=101 (406>>2), busy continuously high.
